// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter feeding the UART transmit byte stream; the grant is held until last or burst limit.
// One IDLE cycle per arbitration; the datapath is combinational in GRANT, and tx_ready passes straight to the owner's req_ready.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [PW-1:0]        owner_q, owner_d, last_q, last_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        pick, off;
  logic [PW:0]          base, sum;
  logic [2*NUM_REQ-1:0] rot;
  logic                 found, own_valid, own_last, xfer, burst_hit;
  logic [7:0]           own_data;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= PW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Rotate the request vector so bit 0 is last_owner+1; the first set bit is the winner.
  always_comb begin
    base  = {1'b0, last_q} + (PW+1)'(1);
    rot   = {req_valid, req_valid} >> base;
    found = 1'b0;
    off   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        off   = PW'(j);
      end
    end
    sum  = base + {1'b0, off};
    pick = (sum >= (PW+1)'(NUM_REQ)) ? PW'(sum - (PW+1)'(NUM_REQ)) : PW'(sum);
  end

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[i*8 +: 8];
      end
    end
  end

  assign xfer      = (state_q == GRANT) && own_valid && tx_ready;
  assign burst_hit = (MAX_BURST != 0) && (cnt_q == CW'(MAX_BURST - 1));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          grant_d = NUM_REQ'(1) << pick;
          owner_d = pick;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          cnt_d = cnt_q + CW'(1);
          if (own_last || burst_hit) begin
            state_d = IDLE;
            grant_d = '0;
            last_d  = owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    grant     = grant_q;
    busy      = (state_q == GRANT);
    if (state_q == GRANT) begin
      tx_valid  = own_valid;
      tx_data   = own_data;
      req_ready = grant_q & {NUM_REQ{tx_ready}};
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues drive random valid/ready traffic;
// a packet-level model predicts the owner, the outputs and the release points every cycle.
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int MAXB  = 4;
  localparam int DEPTH = 1024;

  logic           clk = 1'b0;
  logic           arst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*8-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic           tx_ready = 1'b0;
  logic [N-1:0]   grant;
  logic           busy;

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MAXB)) dut (
    .clk(clk), .arst(arst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [8:0]   sbuf [N][DEPTH];
  int           head [N];
  int           tail [N];
  int           m_owner, m_cnt, m_last;
  int           total, bad;
  int           p_valid, p_ready, stall_r, stall_n, rdy_off;
  int           dut_xfers, model_xfers;
  int           gnt_log [$];
  logic [N-1:0] prev_grant;
  int           rr_exp [5] = '{1, 2, 4, 8, 1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic add_pkt(input int r, input int len, input int base);
    for (int k = 0; k < len; k++) begin
      sbuf[r][tail[r]] = {(k == len - 1), (base >= 0) ? 8'(base + k) : 8'($urandom)};
      tail[r]++;
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (head[i] != tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      logic [8:0] w;
      w = (head[i] < tail[i]) ? sbuf[i][head[i]] : 9'h0;
      req_valid[i] = (head[i] < tail[i]) && ($urandom_range(99) < p_valid) &&
                     !(stall_n > 0 && i == stall_r);
      req_last[i] = w[8];
      req_data[i*8 +: 8] = w[7:0];
    end
    tx_ready = (rdy_off > 0) ? 1'b0 : ($urandom_range(99) < p_ready);
    if (stall_n > 0) stall_n--;
    if (rdy_off > 0) rdy_off--;
  endtask

  // Predict this cycle's outputs from the current owner, then advance the packet-level model.
  task automatic compare_and_model();
    logic [N-1:0] eg, er;
    logic         ev;
    logic [7:0]   ed;
    if (tx_valid && tx_ready) dut_xfers++;
    if (grant != '0 && prev_grant == '0) gnt_log.push_back(int'(grant));
    prev_grant = grant;
    if (m_owner < 0) begin
      eg = '0; ev = 1'b0; ed = '0; er = '0;
    end else begin
      eg = N'(1) << m_owner;
      ev = req_valid[m_owner];
      ed = req_data[m_owner*8 +: 8];
      er = tx_ready ? eg : '0;
    end
    chk("grant", grant, eg);
    chk("busy", busy, (m_owner >= 0));
    chk("tx_valid", tx_valid, ev);
    chk("tx_data", tx_data, ed);
    chk("req_ready", req_ready, er);
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (m_owner < 0 && req_valid[idx]) begin
          m_owner = idx;
          m_cnt   = 0;
        end
      end
    end else if (req_valid[m_owner] && tx_ready) begin
      logic lst;
      lst = sbuf[m_owner][head[m_owner]][8];
      head[m_owner]++;
      m_cnt++;
      model_xfers++;
      if (lst || (MAXB != 0 && m_cnt == MAXB)) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  endtask

  task automatic cycle();
    drive_inputs();
    #4;
    compare_and_model();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int bound);
    bit done;
    done = all_empty() && (m_owner < 0);
    for (int k = 0; k < bound && !done; k++) begin
      cycle();
      done = all_empty() && (m_owner < 0);
    end
    chk("drain", done, 1'b1);
  endtask

  task automatic wait_cnt(input int c);
    bit hit;
    hit = (m_owner >= 0 && m_cnt == c);
    for (int k = 0; k < 300 && !hit; k++) begin
      cycle();
      hit = (m_owner >= 0 && m_cnt == c);
    end
    chk("wait_cnt", hit, 1'b1);
  endtask

  initial begin
    logic [N-1:0] exp_first;
    total = 0; bad = 0; dut_xfers = 0; model_xfers = 0;
    m_owner = -1; m_cnt = 0; m_last = N - 1;
    p_valid = 100; p_ready = 100; stall_r = 0; stall_n = 0; rdy_off = 0;
    prev_grant = '0;
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_req_ready", req_ready, 0);
    arst = 1'b0;

    // Round robin: two 1-byte packets per requester.
    for (int r = 0; r < N; r++) begin add_pkt(r, 1, -1); add_pkt(r, 1, -1); end
    drain(100);
    for (int k = 0; k < 5; k++)
      chk("rr_order", (k < gnt_log.size()) ? gnt_log[k] : 0, rr_exp[k]);

    // Single packet 41,42,43 from requester 2.
    add_pkt(2, 3, 'h41);
    drain(50);

    // Backpressure: tx_ready low for 5 cycles mid-packet.
    add_pkt(1, 6, -1);
    add_pkt(3, 2, -1);
    wait_cnt(2);
    rdy_off = 5;
    drain(100);

    // Burst limit: 10-byte packet on 0 while 1 is pending.
    add_pkt(0, 10, 'h10);
    add_pkt(1, 3, 'h80);
    drain(100);

    // Owner stall for 20 cycles mid-packet with others requesting.
    add_pkt(2, 6, -1);
    add_pkt(0, 2, -1);
    add_pkt(3, 2, -1);
    wait_cnt(2);
    stall_r = m_owner;
    stall_n = 20;
    drain(200);

    // Async reset during byte 2 of 5, with requester 1 also pending.
    add_pkt(3, 5, 'hA0);
    wait_cnt(1);
    add_pkt(1, 2, 'hB0);
    drive_inputs();
    #2 arst = 1'b1;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_busy", busy, 0);
    chk("arst_tx_valid", tx_valid, 0);
    chk("arst_tx_data", tx_data, 0);
    chk("arst_req_ready", req_ready, 0);
    m_owner = -1; m_cnt = 0; m_last = N - 1;
    #1 arst = 1'b0;
    exp_first = '0;
    for (int i = N - 1; i >= 0; i--) if (req_valid[i]) exp_first = N'(1) << i;
    #1;
    compare_and_model();
    @(posedge clk);
    #1;
    chk("rst_first_grant", grant, exp_first);
    drain(100);

    // Random traffic.
    p_valid = 70;
    p_ready = 70;
    for (int k = 0; k < 40; k++) add_pkt($urandom_range(N - 1), $urandom_range(9, 1), -1);
    drain(6000);

    chk("byte_count", dut_xfers, model_xfers);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
